// File: rtl/top1_pkg.sv
// ---------------------------------------------------------------
// top1_pkg: shared defaults for the APB one-shot timer. Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package top1_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int DIV_DEF    = 2;
endpackage

`default_nettype wire

// File: rtl/top1_if.sv
// ---------------------------------------------------------------
// top1_if: APB3-style bus (no PREADY) for the timer slave. Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

interface top1_if
  import top1_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;

  modport slave (
    input  PSEL,
    input  PENABLE,
    input  PWRITE,
    input  PWDATA,
    output PRDATA
  );

  modport master (
    output PSEL,
    output PENABLE,
    output PWRITE,
    output PWDATA,
    input  PRDATA
  );
endinterface

`default_nettype wire

// File: rtl/top1_clk_prescaler.sv
// ---------------------------------------------------------------
// clk_prescaler: free-running divide-by-DIV tick and square-wave strobe. Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module clk_prescaler
  import top1_pkg::*;
#(
  parameter int DIV = DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic tick_o,
  output logic newclk_o
);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             newclk_q, newclk_d;

  assign tick_o   = (cnt_q == CNT_W'(DIV - 1));
  assign newclk_o = newclk_q;

  always_comb begin
    cnt_d    = cnt_q + CNT_W'(1);
    newclk_d = newclk_q;
    // A restart realigns the tick phase to the write that caused it.
    if (restart_i) begin
      cnt_d    = '0;
      newclk_d = 1'b0;
    end else if (tick_o) begin
      cnt_d    = '0;
      newclk_d = ~newclk_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      newclk_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      newclk_q <= newclk_d;
    end
  end
endmodule

`default_nettype wire

// File: rtl/top1.sv
// ---------------------------------------------------------------
// top1: APB-programmed one-shot down-counter with expiry pulse. Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module top1
  import top1_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIV    = DIV_DEF
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  top1_if.slave             apb,
  output logic              trig,
  output logic [DATA_W-1:0] timer_in,
  output logic              newclk_k,
  output logic [DATA_W-1:0] out
);
  logic              setup_seen_q;
  logic              running_q, running_d;
  logic              trig_q, trig_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] timer_in_q, timer_in_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              wr_en;
  logic              tick;

  // Requiring a preceding setup cycle limits each transfer to one write.
  assign wr_en = apb.PSEL & apb.PENABLE & apb.PWRITE & setup_seen_q;

  clk_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk       (PCLK),
    .rst       (PRESETn),
    .restart_i (wr_en),
    .tick_o    (tick),
    .newclk_o  (newclk_k)
  );

  always_comb begin
    out_d      = out_q;
    running_d  = running_q;
    trig_d     = 1'b0;
    timer_in_d = timer_in_q;
    prdata_d   = (apb.PSEL & ~apb.PWRITE) ? out_q : prdata_q;
    if (wr_en) begin
      timer_in_d = apb.PWDATA;
      out_d      = apb.PWDATA;
      running_d  = (apb.PWDATA != '0);
    end else if (tick && running_q && (out_q != '0)) begin
      out_d = out_q - DATA_W'(1);
      if (out_q == DATA_W'(1)) begin
        running_d = 1'b0;
        trig_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      setup_seen_q <= 1'b0;
      running_q    <= 1'b0;
      trig_q       <= 1'b0;
      out_q        <= '0;
      timer_in_q   <= '0;
      prdata_q     <= '0;
    end else begin
      setup_seen_q <= apb.PSEL & ~apb.PENABLE;
      running_q    <= running_d;
      trig_q       <= trig_d;
      out_q        <= out_d;
      timer_in_q   <= timer_in_d;
      prdata_q     <= prdata_d;
    end
  end

  assign apb.PRDATA = prdata_q;
  assign trig       = trig_q;
  assign timer_in   = timer_in_q;
  assign out        = out_q;
endmodule

`default_nettype wire

// File: tb/tb_top1.sv
// ---------------------------------------------------------------
// tb_top1: randomized self-checking bench for the top1 APB timer. Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_top1;
  import top1_pkg::*;

  localparam int DW = DATA_W_DEF;
  localparam int DV = DIV_DEF;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          trig;
  logic          newclk_k;
  logic [DW-1:0] timer_in;
  logic [DW-1:0] out;

  int checks = 0;
  int errors = 0;

  // Reference state: last written value and edges elapsed since that write.
  int m_n   = 0;
  int m_k   = 0;
  int m_tin = 0;

  top1_if #(.DATA_W(DW)) bus ();

  top1 #(
    .DATA_W (DW),
    .DIV    (DV)
  ) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .apb      (bus.slave),
    .trig     (trig),
    .timer_in (timer_in),
    .newclk_k (newclk_k),
    .out      (out)
  );

  always #5 PCLK = ~PCLK;

  function automatic int exp_out(input int n, input int k);
    int v;
    v = n - (k / DV);
    return (v < 0) ? 0 : v;
  endfunction

  function automatic bit exp_trig(input int n, input int k);
    return (n > 0) && (k == n * DV);
  endfunction

  function automatic bit exp_nclk(input int k);
    return ((k / DV) % 2) == 1;
  endfunction

  task automatic step();
    @(posedge PCLK);
    #1;
    m_k++;
  endtask

  task automatic bus_idle();
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
  endtask

  task automatic apb_write(input int v, input bit hold);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b1;
    bus.PWDATA  = DW'(v);
    step();
    bus.PENABLE = 1'b1;
    @(posedge PCLK);
    #1;
    m_n   = v;
    m_k   = 0;
    m_tin = v;
    if (!hold) bus_idle();
  endtask

  task automatic test_reset();
    bus_idle();
    bus.PWDATA = '0;
    PRESETn    = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge PCLK);
      #1;
      checks++;
      if (newclk_k !== 1'b0) begin
        errors++;
        $display("FAIL reset_newclk cyc=%0d: got %b exp 0", i, newclk_k);
      end
    end
    checks++;
    if (out !== '0 || timer_in !== '0 || bus.PRDATA !== '0 || trig !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got out=%0d tin=%0d prdata=%0d trig=%b exp all 0",
               out, timer_in, bus.PRDATA, trig);
    end
    PRESETn = 1'b0;
    m_n = 0; m_k = 0; m_tin = 0;
  endtask

  task automatic test_hold_write();
    int pulses;
    pulses = 0;
    apb_write(2, 1'b1);
    checks++;
    if (timer_in !== DW'(2) || out !== DW'(2)) begin
      errors++;
      $display("FAIL hold_load: got tin=%0d out=%0d exp 2/2", timer_in, out);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      if (trig === 1'b1) pulses++;
      checks++;
      if (out !== DW'(exp_out(m_n, m_k)) || trig !== exp_trig(m_n, m_k) ||
          newclk_k !== exp_nclk(m_k)) begin
        errors++;
        $display("FAIL hold_count k=%0d: got out=%0d trig=%b nclk=%b exp out=%0d trig=%b nclk=%b",
                 m_k, out, trig, newclk_k, exp_out(m_n, m_k), exp_trig(m_n, m_k), exp_nclk(m_k));
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL hold_trig_pulses: got %0d exp 1", pulses);
    end
    bus_idle();
  endtask

  task automatic test_read();
    int kb;
    apb_write(5, 1'b0);
    step();
    step();
    kb          = m_k;
    bus.PSEL    = 1'b1;
    bus.PWRITE  = 1'b0;
    bus.PENABLE = 1'b0;
    step();
    checks++;
    if (bus.PRDATA !== DW'(exp_out(m_n, kb))) begin
      errors++;
      $display("FAIL read_setup: got %0d exp %0d", bus.PRDATA, exp_out(m_n, kb));
    end
    bus.PENABLE = 1'b1;
    step();
    checks++;
    if (bus.PRDATA !== DW'(exp_out(m_n, kb + 1))) begin
      errors++;
      $display("FAIL read_access: got %0d exp %0d", bus.PRDATA, exp_out(m_n, kb + 1));
    end
    bus_idle();
    while (m_k < m_n * DV + 2) begin
      step();
      checks++;
      if (out !== DW'(exp_out(m_n, m_k)) || trig !== exp_trig(m_n, m_k)) begin
        errors++;
        $display("FAIL read_count k=%0d: got out=%0d trig=%b exp out=%0d trig=%b",
                 m_k, out, trig, exp_out(m_n, m_k), exp_trig(m_n, m_k));
      end
    end
  endtask

  task automatic test_write_zero();
    apb_write(7, 1'b0);
    step();
    apb_write(0, 1'b0);
    checks++;
    if (out !== '0 || timer_in !== '0) begin
      errors++;
      $display("FAIL zero_load: got out=%0d tin=%0d exp 0/0", out, timer_in);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (out !== '0 || trig !== 1'b0) begin
        errors++;
        $display("FAIL zero_idle k=%0d: got out=%0d trig=%b exp 0/0", m_k, out, trig);
      end
    end
  endtask

  task automatic test_reset_midcount();
    apb_write(200, 1'b0);
    repeat (10) step();
    checks++;
    if (out !== DW'(exp_out(m_n, m_k))) begin
      errors++;
      $display("FAIL midrst_pre: got %0d exp %0d", out, exp_out(m_n, m_k));
    end
    PRESETn = 1'b1;
    @(posedge PCLK);
    #1;
    checks++;
    if (out !== '0 || trig !== 1'b0 || timer_in !== '0 || newclk_k !== 1'b0) begin
      errors++;
      $display("FAIL midrst_post: got out=%0d trig=%b tin=%0d nclk=%b exp all 0",
               out, trig, timer_in, newclk_k);
    end
    PRESETn = 1'b0;
    m_n = 0; m_k = 0; m_tin = 0;
  endtask

  task automatic test_rewrite();
    int pulses;
    int at_k;
    pulses = 0;
    at_k   = -1;
    apb_write(10, 1'b0);
    repeat (5) step();
    apb_write(3, 1'b0);
    checks++;
    if (out !== DW'(3) || timer_in !== DW'(3)) begin
      errors++;
      $display("FAIL rewrite_load: got out=%0d tin=%0d exp 3/3", out, timer_in);
    end
    for (int i = 0; i < 9; i++) begin
      step();
      if (trig === 1'b1) begin
        pulses++;
        at_k = m_k;
      end
    end
    checks++;
    if (pulses != 1 || at_k != 3 * DV) begin
      errors++;
      $display("FAIL rewrite_expiry: got pulses=%0d at k=%0d exp 1 at k=%0d", pulses, at_k, 3 * DV);
    end
  endtask

  task automatic test_random();
    int v;
    int n_cyc;
    bit hold;
    for (int it = 0; it < 16; it++) begin
      v     = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
      hold  = 1'($urandom_range(0, 1));
      apb_write(v, hold);
      checks++;
      if (timer_in !== DW'(m_tin) || out !== DW'(v)) begin
        errors++;
        $display("FAIL rnd_load it=%0d: got tin=%0d out=%0d exp %0d", it, timer_in, out, v);
      end
      n_cyc = int'($urandom_range(1, v * DV + 4));
      for (int i = 0; i < n_cyc; i++) begin
        step();
        checks++;
        if (out !== DW'(exp_out(m_n, m_k)) || trig !== exp_trig(m_n, m_k) ||
            newclk_k !== exp_nclk(m_k)) begin
          errors++;
          $display("FAIL rnd_count it=%0d k=%0d: got out=%0d trig=%b nclk=%b exp out=%0d trig=%b nclk=%b",
                   it, m_k, out, trig, newclk_k, exp_out(m_n, m_k), exp_trig(m_n, m_k), exp_nclk(m_k));
        end
      end
      bus_idle();
      if ($urandom_range(0, 2) == 0) begin
        bus.PSEL = 1'b1;
        step();
        checks++;
        if (bus.PRDATA !== DW'(exp_out(m_n, m_k - 1))) begin
          errors++;
          $display("FAIL rnd_read it=%0d: got %0d exp %0d", it, bus.PRDATA, exp_out(m_n, m_k - 1));
        end
        bus_idle();
      end
    end
  endtask

  initial begin
    test_reset();
    test_hold_write();
    test_read();
    test_write_zero();
    test_reset_midcount();
    test_rewrite();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/top1.md
Name: top1

Overview:
- APB-slave programmable one-shot down-counter timer with an 8-bit data path.
- Software writes a start value over a zero-wait-state APB3-style write (no PREADY). The block then decrements it once per prescaler tick and pulses `trig` when the count reaches zero.
- It also exports a divided clock-like strobe `newclk_k`, the last programmed value, and the live count.
- It sits as a leaf peripheral on the APB bus of the timer subsystem.

Parameters:
- DATA_W, 8, width of PWDATA/PRDATA/timer_in/out.
- DIV, 2, prescaler: one count tick every DIV PCLK cycles (DIV >= 1).

Ports:
- PCLK  in  1  system clock; all logic on its rising edge.
- PRESETn  in  1  reset. Synchronous, active-high: 1 = reset, despite the name.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PWDATA  in  DATA_W  write data (timer start value).
- trig  out  1  one-PCLK pulse when the count expires.
- PRDATA  out  DATA_W  read data (current count).
- timer_in  out  DATA_W  last value written.
- newclk_k  out  1  prescaler square wave; toggles on every tick, period 2*DIV PCLK cycles.
- out  out  DATA_W  current count value.

Behaviour:
- One clock domain (PCLK). `newclk_k` is a registered output only; no logic is clocked by it.
- **Reset** (PRESETn=1 at a rising edge): timer_in=0, out=0, PRDATA=0, trig=0, newclk_k=0, prescaler count=0, running=0, setup_seen=0.
  - Reset has priority over everything, including mid-count.
- **Setup tracking**: setup_seen <= PSEL & ~PENABLE every cycle.
- **Write acceptance**: PSEL & PENABLE & PWRITE & setup_seen. This gives exactly one write per transfer. Holding PENABLE high across further cycles causes no re-writes.
- **On an accepted write**:
  - timer_in <= PWDATA; out <= PWDATA.
  - running <= (PWDATA != 0); trig <= 0.
  - Prescaler count <= 0; newclk_k <= 0.
- **Read**: when PSEL & ~PWRITE, PRDATA <= out (registered, so valid in the access phase). Otherwise PRDATA holds its value.
- **Prescaler**: counts 0..DIV-1 while not reset. A tick is the cycle in which count == DIV-1; count then wraps to 0 and newclk_k toggles. The prescaler free-runs whether or not the timer is running.
- **Decrement**: on a tick with running=1, out <= out-1. There is no underflow wrap: out never goes below 0.
- **Expiry**: when a decrement makes out 1 -> 0:
  - trig = 1 for exactly the following PCLK cycle;
  - running <= 0.
  - One-shot: the timer stays at 0 until the next write. There is no auto-reload.
- **Write of 0**: out=0, running=0, no trig pulse.
- **Write in the same cycle as a tick**: the write wins; no decrement happens that cycle.
- **Latency**: the first decrement occurs DIV cycles after the accepted-write edge. Expiry occurs N*DIV cycles after a write of N.
- Reads never disturb the count.

Decomposition:
- Shared package: DATA_W default and DIV default constants. No typedefs are needed.
- One natural sub-module, `clk_prescaler`, holding the DIV counter, the tick strobe and newclk_k, with a synchronous restart input.
- The APB decode, count register and trig logic stay in top1.

Test Plan:
- Reset: PRESETn=1 for 2 cycles -> all outputs 0; newclk_k stays 0.
- Write 2 (setup phase, then PSEL/PENABLE/PWRITE held high 8 cycles, DIV=2):
  - timer_in=2 and out=2 after the access edge;
  - out=1 two cycles later, out=0 four cycles later;
  - trig high for exactly one cycle, then stays 0;
  - holding PENABLE causes no reload.
- Read: after writing 5, do a read transfer mid-count -> PRDATA equals `out` at the setup edge (e.g. 4); the count is unaffected.
- Write 0 -> out=0, trig never asserts, running stays 0.
- Reset mid-count: write 200, assert PRESETn after 10 cycles -> out=0, trig=0, timer_in=0 next edge.
- Rewrite mid-count: write 10, then write 3 before expiry -> out=3 immediately; expiry 6 cycles later with a single trig pulse.
